axi4_wr_chan: RTL and testbench
===============================

Name: axi4_wr_chan

Overview:
- Sits directly downstream of tlul_to_axi4 and consumes its decoded write commands.
- Drives the AXI4 AW and W channels as single-beat bursts, waits for the B response, and returns a per-source completion. Upstream turns that completion into a TL-D AccessAck.
- Tracks up to Depth outstanding writes in order under a single fixed AXI ID.

Parameters:
- AddrWidth, 32, address width.
- DataWidth, 64, data width; strobe width is DataWidth/8.
- SourceWidth, 8, TileLink source tag width.
- IdWidth, 8, AXI ID width.
- AxiId, 0, constant AWID used for every write.
- Depth, 4, maximum outstanding writes; power of two, 2 to 16.
- TimeoutCycles, 1024, B timeout when the optional feature is enabled.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid  in  1  write command valid
- cmd_ready  out  1  command accepted when valid & ready
- cmd_addr  in  AddrWidth  byte address
- cmd_size  in  3  log2 bytes, 0..log2(DataWidth/8)
- cmd_data  in  DataWidth  write data
- cmd_strb  in  DataWidth/8  byte strobes
- cmd_source  in  SourceWidth  TL source tag
- axi_awid/awaddr/awlen/awsize/awburst/awcache/awprot  out  IdWidth/AddrWidth/8/3/2/4/3  AW payload
- axi_awvalid  out  1
- axi_awready  in  1
- axi_wdata/wstrb/wlast  out  DataWidth/DataWidth/8/1  W payload
- axi_wvalid  out  1
- axi_wready  in  1
- axi_bid  in  IdWidth
- axi_bresp  in  2
- axi_bvalid  in  1
- axi_bready  out  1
- rsp_valid  out  1  completion valid
- rsp_ready  in  1
- rsp_source  out  SourceWidth  source of the completed write
- rsp_error  out  1  1 when bresp is SLVERR/DECERR or on timeout
- outstanding  out  $clog2(Depth)+1  count of in-flight writes
- err_unexpected_b  out  1  sticky; set when B arrives with no write outstanding

Behaviour:
- Reset values: every valid output 0, axi_bready 0, outstanding 0, err_unexpected_b 0, all registered payloads 0.
- Constant AW fields: awid=AxiId, awlen=0, awburst=INCR(01), awcache=0011, awprot=000. wlast is always 1.
- FSM has two states:
  - IDLE: cmd_ready = (outstanding < Depth). On a command handshake, register the payload, raise awvalid and wvalid in the next cycle, and go to SEND.
  - SEND: awvalid and wvalid are independent. Each drops after its own handshake (aw_done, w_done flags); they may complete in either order or in the same cycle. Payload is stable while valid. When both are done: push cmd_source into the tracking FIFO, return to IDLE, cmd_ready=0 this cycle.
- Command latency: a new command is accepted at most every 2 cycles. AW/W are visible 1 cycle after the command handshake.
- Outstanding counter:
  - Increments on FIFO push, decrements on B pop.
  - A simultaneous push and pop leaves it unchanged.
  - When full, cmd_ready=0.
- B path:
  - axi_bready = (outstanding != 0) & (!rsp_valid | rsp_ready).
  - On a B handshake: pop the FIFO head into rsp_source, rsp_error = bresp[1], and rsp_valid=1 next cycle.
  - rsp_valid holds until rsp_ready.
  - bid is not checked.
- B with bvalid while outstanding==0: bready stays 0, and err_unexpected_b sets when bvalid is seen. It clears only on reset.
- FIFO pointers wrap modulo Depth; occupancy is held in the outstanding counter.
- Reset mid-transaction drops all in-flight state immediately. The bench must not expect completions for writes issued before reset.

Optional Feature:
- Macro: AXI4_WR_CHAN_TIMEOUT_EN.
- Defined: a counter runs while outstanding != 0 and no B handshake occurs; it resets on each B handshake or pop. When it reaches TimeoutCycles-1, the block pops the FIFO head and emits a response with rsp_error=1 (only if the rsp slot is free; otherwise it waits). A late B for a timed-out write is then matched against the next entry, so the feature is for debug builds only.
- Not defined: no counter is built and writes wait indefinitely.

Decomposition:
- Package axi4_wr_pkg holds:
  - BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR, the AWCACHE default.
  - The state enum typedef {IDLE, SEND}.
  - The wr_cmd_t struct (addr, size, data, strb, source).
- One sub-module, axi4_wr_src_fifo: a synchronous FIFO with parameters Depth and SourceWidth, plus push/pop/full/empty/count.

Test Plan:
- Single write: cmd addr 0x12345678, data 0xAABBCCDDEEFF0011, strb 0xFF, size 3, source 0x01; awready=wready=1; B OKAY after 3 cycles -> awaddr=0x12345678, awsize=3, awlen=0, wlast=1; then rsp_valid with source 0x01, error 0.
- AW/W skew: awready held low 5 cycles while wready=1 -> W completes first, wvalid drops, awvalid holds with stable payload; exactly one FIFO push.
- Error response: source 0x03, strb 0x0F, bresp=SLVERR -> rsp_error=1, rsp_source=0x03.
- Back-pressure and full: 4 writes (sources 0x10..0x13) with bvalid=0 -> outstanding=4 and cmd_ready=0 on the 5th. Then 4 B OKAY with rsp_ready=0 for 3 cycles -> bready=0 while rsp stalled; responses emerge in order 0x10..0x13.
- Stray B: bvalid with outstanding=0 -> bready=0, err_unexpected_b=1 and sticky until rst_ni low.
- Timeout (macro defined, TimeoutCycles=16): one write, no B -> rsp_valid with error=1 after 16 cycles of waiting; outstanding returns to 0.

Source files
------------

// File: rtl/axi4_wr_pkg.sv
// Shared constants and types for the AXI4 single-beat write channel.
// Fields of wr_cmd_t use the block's default widths; the top casts to its own parameters.
package axi4_wr_pkg;

  localparam logic [1:0] BURST_INCR      = 2'b01;
  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [1:0] RESP_EXOKAY     = 2'b01;
  localparam logic [1:0] RESP_SLVERR     = 2'b10;
  localparam logic [1:0] RESP_DECERR     = 2'b11;
  localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 64;
  localparam int CMD_SRC_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0]   addr;
    logic [2:0]              size;
    logic [CMD_DATA_W-1:0]   data;
    logic [CMD_DATA_W/8-1:0] strb;
    logic [CMD_SRC_W-1:0]    source;
  } wr_cmd_t;

endpackage

// File: rtl/axi4_wr_src_fifo.sv
// In-order FIFO of TileLink source tags for writes waiting on their B response.
module axi4_wr_src_fifo #(
  parameter int Depth       = 4,
  parameter int SourceWidth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       i_push,
  input  logic [SourceWidth-1:0]     i_push_data,
  input  logic                       i_pop,
  output logic [SourceWidth-1:0]     o_pop_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(Depth):0]     o_count
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;

  logic [SourceWidth-1:0] r_mem [Depth];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   w_push_ok;
  logic                   w_pop_ok;

  assign o_full     = (r_count == CW'(Depth));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_push_ok  = i_push & ~o_full;
  assign w_pop_ok   = i_pop & ~o_empty;

  // Pointers are PW bits wide, so wrap modulo Depth comes for free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi4_wr_chan.sv
// AXI4 write channel: single-beat AW/W per command, in-order B tracking, per-source completion.
// Optional B timeout is built when AXI4_WR_CHAN_TIMEOUT_EN is defined.
module axi4_wr_chan
  import axi4_wr_pkg::*;
#(
  parameter int                 AddrWidth     = 32,
  parameter int                 DataWidth     = 64,
  parameter int                 SourceWidth   = 8,
  parameter int                 IdWidth       = 8,
  parameter logic [IdWidth-1:0] AxiId         = '0,
  parameter int                 Depth         = 4,
  parameter int                 TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [AddrWidth-1:0]     cmd_addr,
  input  logic [2:0]               cmd_size,
  input  logic [DataWidth-1:0]     cmd_data,
  input  logic [DataWidth/8-1:0]   cmd_strb,
  input  logic [SourceWidth-1:0]   cmd_source,
  output logic [IdWidth-1:0]       axi_awid,
  output logic [AddrWidth-1:0]     axi_awaddr,
  output logic [7:0]               axi_awlen,
  output logic [2:0]               axi_awsize,
  output logic [1:0]               axi_awburst,
  output logic [3:0]               axi_awcache,
  output logic [2:0]               axi_awprot,
  output logic                     axi_awvalid,
  input  logic                     axi_awready,
  output logic [DataWidth-1:0]     axi_wdata,
  output logic [DataWidth/8-1:0]   axi_wstrb,
  output logic                     axi_wlast,
  output logic                     axi_wvalid,
  input  logic                     axi_wready,
  input  logic [IdWidth-1:0]       axi_bid,
  input  logic [1:0]               axi_bresp,
  input  logic                     axi_bvalid,
  output logic                     axi_bready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [SourceWidth-1:0]   rsp_source,
  output logic                     rsp_error,
  output logic [$clog2(Depth):0]   outstanding,
  output logic                     err_unexpected_b,
  output wr_state_e                dbg_state
);

  // Handshake rule on every channel: a beat transfers on a rising clk_i edge where
  // valid and ready are both high; a raised valid and its payload hold until then.

  wr_state_e               r_state;
  wr_cmd_t                 r_cmd;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_rsp_valid;
  logic                    r_rsp_error;
  logic [SourceWidth-1:0]  r_rsp_source;
  logic                    r_err_unexp;

  logic                    w_full;
  logic                    w_empty;
  logic [SourceWidth-1:0]  w_head;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_aw_done;
  logic                    w_w_done;
  logic                    w_rsp_free;
  logic                    w_b_hs;
  logic                    w_b_err;
  logic                    w_to_fire;
  logic                    w_unused_bid;

  assign cmd_ready   = (r_state == IDLE) & ~w_full;
  assign w_aw_done   = ~r_awvalid | axi_awready;
  assign w_w_done    = ~r_wvalid | axi_wready;
  assign w_push      = (r_state == SEND) & w_aw_done & w_w_done;
  assign w_rsp_free  = ~r_rsp_valid | rsp_ready;
  assign axi_bready  = ~w_empty & w_rsp_free;
  assign w_b_hs      = axi_bvalid & axi_bready;
  assign w_b_err     = (axi_bresp == RESP_SLVERR) | (axi_bresp == RESP_DECERR);
  assign w_pop       = w_b_hs | w_to_fire;
  assign w_unused_bid = ^axi_bid;

  assign axi_awid    = AxiId;
  assign axi_awaddr  = AddrWidth'(r_cmd.addr);
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = r_cmd.size;
  assign axi_awburst = BURST_INCR;
  assign axi_awcache = AWCACHE_DEFAULT;
  assign axi_awprot  = 3'b000;
  assign axi_awvalid = r_awvalid;
  assign axi_wdata   = DataWidth'(r_cmd.data);
  assign axi_wstrb   = (DataWidth/8)'(r_cmd.strb);
  assign axi_wlast   = 1'b1;
  assign axi_wvalid  = r_wvalid;

  assign rsp_valid        = r_rsp_valid;
  assign rsp_source       = r_rsp_source;
  assign rsp_error        = r_rsp_error;
  assign err_unexpected_b = r_err_unexp;
  assign dbg_state        = r_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_cmd     <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_cmd.addr   <= CMD_ADDR_W'(cmd_addr);
            r_cmd.size   <= cmd_size;
            r_cmd.data   <= CMD_DATA_W'(cmd_data);
            r_cmd.strb   <= (CMD_DATA_W/8)'(cmd_strb);
            r_cmd.source <= CMD_SRC_W'(cmd_source);
            r_awvalid    <= 1'b1;
            r_wvalid     <= 1'b1;
            r_state      <= SEND;
          end
        end
        SEND: begin
          if (r_awvalid && axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && axi_wready)   r_wvalid  <= 1'b0;
          if (w_push) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_error  <= 1'b0;
      r_rsp_source <= '0;
      r_err_unexp  <= 1'b0;
    end else begin
      if (w_b_hs) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_source <= w_head;
        r_rsp_error  <= w_b_err;
      end else if (w_to_fire) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_source <= w_head;
        r_rsp_error  <= 1'b1;
      end else if (rsp_ready) begin
        r_rsp_valid  <= 1'b0;
      end
      if (axi_bvalid && w_empty) r_err_unexp <= 1'b1;
    end
  end

`ifdef AXI4_WR_CHAN_TIMEOUT_EN
  localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [TW-1:0] r_to_cnt;

  // A timed-out head is retired only once the response slot can take it.
  assign w_to_fire = ~w_empty & ~w_b_hs & w_rsp_free & (r_to_cnt == TW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt <= '0;
    end else if (w_empty || w_pop) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TW'(TimeoutCycles - 1)) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_to_fire        = 1'b0;
  assign w_unused_timeout = 32'(TimeoutCycles);
`endif

  axi4_wr_src_fifo #(
    .Depth       (Depth),
    .SourceWidth (SourceWidth)
  ) u_src_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_push      (w_push),
    .i_push_data (SourceWidth'(r_cmd.source)),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (outstanding)
  );

endmodule

// File: tb/tb_axi4_wr_chan.sv
// Self-checking bench for axi4_wr_chan: drivers, negedge monitors, scoreboard queues.
// The timeout scenario runs only when AXI4_WR_CHAN_TIMEOUT_EN is defined.
module tb_axi4_wr_chan;
  import axi4_wr_pkg::*;

  localparam int AW = 32, DW = 64, SW = 8, IW = 8, DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr = '0;
  logic [2:0]      cmd_size = '0;
  logic [DW-1:0]   cmd_data = '0;
  logic [DW/8-1:0] cmd_strb = '0;
  logic [SW-1:0]   cmd_source = '0;
  logic [IW-1:0]   axi_awid;
  logic [AW-1:0]   axi_awaddr;
  logic [7:0]      axi_awlen;
  logic [2:0]      axi_awsize;
  logic [1:0]      axi_awburst;
  logic [3:0]      axi_awcache;
  logic [2:0]      axi_awprot;
  logic            axi_awvalid;
  logic            axi_awready = 1'b1;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_wlast;
  logic            axi_wvalid;
  logic            axi_wready = 1'b1;
  logic [IW-1:0]   axi_bid = '0;
  logic [1:0]      axi_bresp = '0;
  logic            axi_bvalid = 1'b0;
  logic            axi_bready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [SW-1:0]   rsp_source;
  logic            rsp_error;
  logic [2:0]      outstanding;
  logic            err_unexpected_b;
  wr_state_e       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [34:0]   exp_aw_q[$];
  logic [71:0]   exp_w_q[$];
  logic [8:0]    exp_rsp_q[$];
  logic [SW-1:0] model_src_q[$];

  axi4_wr_chan #(
    .AddrWidth(AW), .DataWidth(DW), .SourceWidth(SW), .IdWidth(IW),
    .AxiId(8'h00), .Depth(DEPTH), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .cmd_source(cmd_source),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awcache(axi_awcache),
    .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_source(rsp_source),
    .rsp_error(rsp_error), .outstanding(outstanding),
    .err_unexpected_b(err_unexpected_b), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitors sample at negedge; a beat seen here completes on the next posedge.
  logic [34:0] m_aw;
  logic [71:0] m_w;
  logic [8:0]  m_rsp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (axi_awvalid && axi_awready) begin
        check_eq("aw_expected", 72'(exp_aw_q.size() != 0), 72'(1));
        if (exp_aw_q.size() != 0) begin
          m_aw = exp_aw_q.pop_front();
          check_eq("awaddr", 72'(axi_awaddr), 72'(m_aw[34:3]));
          check_eq("awsize", 72'(axi_awsize), 72'(m_aw[2:0]));
          check_eq("aw_const", 72'({axi_awid, axi_awlen, axi_awburst, axi_awcache, axi_awprot}),
                   72'({8'h00, 8'h00, 2'b01, 4'b0011, 3'b000}));
        end
      end
      if (axi_wvalid && axi_wready) begin
        check_eq("w_expected", 72'(exp_w_q.size() != 0), 72'(1));
        if (exp_w_q.size() != 0) begin
          m_w = exp_w_q.pop_front();
          check_eq("wdata_wstrb", 72'({axi_wdata, axi_wstrb}), m_w);
          check_eq("wlast", 72'(axi_wlast), 72'(1));
        end
      end
      if (axi_bvalid && axi_bready) begin
        check_eq("b_has_write", 72'(model_src_q.size() != 0), 72'(1));
        if (model_src_q.size() != 0) exp_rsp_q.push_back({model_src_q.pop_front(), axi_bresp[1]});
      end
      if (rsp_valid && rsp_ready) begin
        check_eq("rsp_expected", 72'(exp_rsp_q.size() != 0), 72'(1));
        if (exp_rsp_q.size() != 0) begin
          m_rsp = exp_rsp_q.pop_front();
          check_eq("rsp_source", 72'(rsp_source), 72'(m_rsp[8:1]));
          check_eq("rsp_error", 72'(rsp_error), 72'(m_rsp[0]));
        end
      end
    end
  end

  // Drivers start and end just after a posedge.
  task automatic send_cmd(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d,
                          input logic [7:0] st, input logic [7:0] src);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_size = sz; cmd_data = d; cmd_strb = st; cmd_source = src;
    while (!done && n < 100) begin
      @(negedge clk);
      if (cmd_ready) done = 1'b1;
      n++;
    end
    check_eq("cmd_accept", 72'(done), 72'(1));
    if (done) begin
      exp_aw_q.push_back({a, sz});
      exp_w_q.push_back({d, st});
      model_src_q.push_back(src);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp, input int delay);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    repeat (delay) begin @(posedge clk); #1; end
    axi_bvalid = 1'b1;
    axi_bresp  = resp;
    while (!done && n < 100) begin
      @(negedge clk);
      if (axi_bready) done = 1'b1;
      n++;
    end
    check_eq("b_accept", 72'(done), 72'(1));
    @(posedge clk); #1;
    axi_bvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (exp_aw_q.size() == 0 && exp_w_q.size() == 0 && exp_rsp_q.size() == 0 &&
          model_src_q.size() == 0 && outstanding == 3'd0 && !rsp_valid) done = 1'b1;
      n++;
    end
    check_eq("drain", 72'(done), 72'(1));
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; axi_bvalid = 1'b0;
    exp_aw_q.delete(); exp_w_q.delete(); exp_rsp_q.delete(); model_src_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0] src;
    logic [1:0] resp;

    apply_reset();
    @(negedge clk);
    check_eq("rst_valids", 72'({axi_awvalid, axi_wvalid, axi_bready, rsp_valid}), 72'(0));
    check_eq("rst_outstanding", 72'(outstanding), 72'(0));
    check_eq("rst_err_unexp", 72'(err_unexpected_b), 72'(0));
    check_eq("rst_payload", 72'({axi_awaddr, axi_wdata[31:0]}), 72'(0));
    check_eq("rst_state", 72'(dbg_state), 72'(IDLE));
    check_eq("rst_cmd_ready", 72'(cmd_ready), 72'(1));
    @(posedge clk); #1;

    // Single write, AW/W visible one cycle after the command
    send_cmd(32'h1234_5678, 3'd3, 64'hAABB_CCDD_EEFF_0011, 8'hFF, 8'h01);
    @(negedge clk);
    check_eq("aw_w_latency", 72'({axi_awvalid, axi_wvalid}), 72'(2'b11));
    @(posedge clk); #1;
    send_b(RESP_OKAY, 3);
    wait_idle();

    // AW held off while W completes
    axi_awready = 1'b0;
    send_cmd(32'h0000_1000, 3'd3, 64'h1122_3344_5566_7788, 8'hF0, 8'h02);
    @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      check_eq("skew_wvalid", 72'(axi_wvalid), 72'(0));
      check_eq("skew_awvalid", 72'(axi_awvalid), 72'(1));
      check_eq("skew_awaddr", 72'(axi_awaddr), 72'(32'h0000_1000));
      check_eq("skew_no_push", 72'(outstanding), 72'(0));
    end
    @(posedge clk); #1;
    axi_awready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("skew_one_push", 72'(outstanding), 72'(1));
    check_eq("skew_aw_dropped", 72'(axi_awvalid), 72'(0));
    send_b(RESP_OKAY, 1);
    wait_idle();

    // Error responses
    send_cmd(32'h2000_0004, 3'd2, 64'h0000_0000_CAFE_F00D, 8'h0F, 8'h03);
    send_b(RESP_SLVERR, 2);
    send_cmd(32'h3000_0008, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 8'h04);
    send_b(RESP_DECERR, 1);
    wait_idle();

    // Fill to Depth, then drain under response back-pressure
    for (int i = 0; i < 4; i++)
      send_cmd(32'h100 * (i + 1), 3'd3, 64'hDEAD_0000 + 64'(i), 8'hFF, 8'h10 + 8'(i));
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("full_outstanding", 72'(outstanding), 72'(4));
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_source = 8'h14;
    repeat (3) begin
      @(negedge clk);
      check_eq("full_cmd_ready", 72'(cmd_ready), 72'(0));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_b(RESP_OKAY, 0);
      end
      begin
        @(negedge clk);
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_bready", 72'(axi_bready), 72'(0));
          check_eq("stall_rsp_hold", 72'(rsp_valid), 72'(1));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // Randomised writes
    for (int i = 0; i < 8; i++) begin
      src  = 8'($urandom_range(0, 255));
      resp = 2'($urandom_range(0, 3));
      send_cmd($urandom, 3'($urandom_range(0, 3)), {$urandom, $urandom}, 8'($urandom_range(0, 255)), src);
      send_b(resp, $urandom_range(1, 4));
    end
    wait_idle();
    check_eq("no_unexpected_b", 72'(err_unexpected_b), 72'(0));

`ifdef AXI4_WR_CHAN_TIMEOUT_EN
    // No B ever arrives: the head retires with an error
    send_cmd(32'h4000_0000, 3'd3, 64'h5555_AAAA_5555_AAAA, 8'hFF, 8'h20);
    void'(model_src_q.pop_back());
    exp_rsp_q.push_back({8'h20, 1'b1});
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_latency", 72'(n >= 16 && n <= 18), 72'(1));
    @(posedge clk); #1;
    wait_idle();
`endif

    // Reset drops in-flight writes
    send_cmd(32'h5000_0000, 3'd3, 64'h1, 8'h01, 8'h21);
    send_cmd(32'h5000_0008, 3'd3, 64'h2, 8'h01, 8'h22);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mid_outstanding", 72'(outstanding), 72'(2));
    @(posedge clk); #1;
    apply_reset();
    @(negedge clk);
    check_eq("post_rst_outstanding", 72'(outstanding), 72'(0));
    check_eq("post_rst_rsp", 72'({rsp_valid, axi_bready}), 72'(0));
    @(posedge clk); #1;
    send_cmd(32'h6000_0000, 3'd3, 64'h3, 8'hFF, 8'h30);
    send_b(RESP_OKAY, 2);
    wait_idle();

    // Stray B with nothing outstanding
    axi_bvalid = 1'b1;
    axi_bresp  = RESP_OKAY;
    @(negedge clk);
    check_eq("stray_bready", 72'(axi_bready), 72'(0));
    @(posedge clk); #1;
    axi_bvalid = 1'b0;
    @(negedge clk);
    check_eq("stray_err_set", 72'(err_unexpected_b), 72'(1));
    repeat (5) @(posedge clk);
    #1;
    check_eq("stray_err_sticky", 72'(err_unexpected_b), 72'(1));
    rst_n = 1'b0;
    #1;
    check_eq("stray_err_cleared", 72'(err_unexpected_b), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
